axi4_lite_regfile: RTL and testbench
====================================

# axi4_lite_regfile

AXI4-Lite slave register bank that terminates transactions issued by the strobe-driven AXI4-Lite master adapter, or by any other AXI4-Lite master. It exposes REG_CNT word-wide control registers to the fabric as a flat vector. Registers selected by RO_MASK are read-only status words fed from fabric logic. Write and read channels are fully decoupled. AW and W beats are accepted in any order or in the same cycle, which matches a master that raises awvalid and wvalid together.

## Interface
- DATA_WIDTH, 32: AXI data width; power of two, at least 8.
- ADDR_WIDTH, 32: AXI address width.
- REG_CNT, 8: number of registers, at least 1.
- RO_MASK, '0 (REG_CNT bits): bit i set makes register i read-only.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- axi4_lite_i  axi4_lite_if.slave  -  AXI4-Lite slave port. It carries aw/w/b/ar/r channels with awprot and arprot, which are ignored.
- status_i  in  REG_CNT*DATA_WIDTH  read values for RO registers; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- regs_o  out  REG_CNT*DATA_WIDTH  current RW register contents; RO slots drive 0.
- wr_pulse_o  out  REG_CNT  one-cycle pulse on bit i when register i is written.

## Operation
- Word index = addr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- Write path:
  - Holds one AW slot (index) and one W slot (wdata, wstrb).
  - awready = AW slot empty; wready = W slot empty.
  - Each slot captures its beat on its own handshake.
- Write commit occurs when both slots are full and (!bvalid || bready). In the commit cycle:
  - RW register in range: bytes with wstrb[b]=1 are updated; wr_pulse_o[i]=1; bresp=2'b00 (OKAY).
  - RO register: no update; no pulse; bresp=2'b10 (SLVERR).
  - index >= REG_CNT: no update; bresp=2'b11 (DECERR).
  - Both slots clear and bvalid is set. bvalid holds with a stable bresp until bready.
- Read path:
  - arready = !rvalid || rready.
  - On AR handshake, rvalid is set and rdata/rresp are registered:
    - RW register: register value, OKAY.
    - RO register: status_i word sampled in the handshake cycle, OKAY.
    - Out of range: 0, DECERR.
  - rvalid, rdata and rresp hold until rready.
- Read and write of the same register in the same cycle: the read returns the pre-write value.
- Reset values: all registers 0, regs_o 0, slots empty, bvalid 0, rvalid 0, bresp 0, rresp 0, rdata 0, wr_pulse_o 0.
  - awready, wready and arready are high in the first cycle after reset release.
- Reset asserted mid-transaction aborts all pending slots and responses immediately; no partial write is committed.

## Timing
- AW and W handshakes in cycle c (same cycle or the later of the two): register update, wr_pulse_o and bvalid are visible in cycle c+2.
- wr_pulse_o is exactly one cycle wide, coincident with the first bvalid cycle.
- With bready held high, back-to-back writes sustain one write per 2 cycles.
  - A slot refills in the cycle after commit.
  - The next commit is not blocked, because bvalid && bready frees B.
- With bready low, both slots may fill, but commit stalls until bready. awready and wready then stay low.
- AR handshake in cycle c: rvalid visible in cycle c+1.
  - With rready held high, one read per cycle.
  - With rready low, arready is low while rvalid is high.
- AW accepted without W, or W without AW: the slot is held indefinitely, with no timeout and no bvalid.

## Test plan
- Write addr 0x4, data 0xDEADBEEF, wstrb 4'hF, with awvalid and wvalid together -> bvalid in cycle c+2, bresp 0; regs_o word1 = 0xDEADBEEF; wr_pulse_o = 8'h02 for one cycle; a read of 0x4 returns 0xDEADBEEF with rresp 0.
- Send W three cycles before AW to 0x8, data 0x12345678, wstrb 4'b0101 -> wready drops after the W beat; after AW, word2 = 0x00340078; exactly one bvalid.
- With RO_MASK=8'h80 and status_i word7=0xCAFEF00D: write 0x1C -> SLVERR, no pulse; read 0x1C -> 0xCAFEF00D, OKAY.
- Write and read 0x40 (index 16 >= REG_CNT) -> bresp 2'b11; rdata 0, rresp 2'b11; regs_o unchanged.
- Hold bready low after one write; issue a second write -> second AW/W captured, awready/wready low, no commit; raise bready -> first B completes, second commits next cycle.
- Assert rst_i with AW captured and W pending -> all outputs return to reset values asynchronously; after release, W alone produces no bvalid.

Source files
------------

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle: aw/w/b/ar/r channels with valid/ready handshakes.
// The master modport drives requests; the slave modport drives ready and responses.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;

    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;

    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;

    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;

    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite register bank: writes land 2 cycles after the later AW/W beat, reads 1 cycle after AR.
// One AW and one W slot; a held B stalls commits (ready drops once slots fill), a held R drops arready.
module axi4_lite_regfile #(
    parameter int                DATA_WIDTH = 32,
    parameter int                ADDR_WIDTH = 32,
    parameter int                REG_CNT    = 8,
    parameter logic [REG_CNT-1:0] RO_MASK   = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    axi4_lite_if.slave                    axi4_lite_i,
    input  logic [REG_CNT*DATA_WIDTH-1:0] status_i,
    output logic [REG_CNT*DATA_WIDTH-1:0] regs_o,
    output logic [REG_CNT-1:0]            wr_pulse_o
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFS = $clog2(NB);
    localparam int IW   = ADDR_WIDTH - OFFS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [REG_CNT-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [REG_CNT-1:0]                 pulse_q, pulse_d;

    logic                  aw_full_q, aw_full_d;
    logic [IW-1:0]         aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NB-1:0]         w_strb_q, w_strb_d;

    logic                  b_vld_q, b_vld_d;
    logic [1:0]            b_resp_q, b_resp_d;

    logic                  r_vld_q, r_vld_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;

    logic aw_hs, w_hs, ar_hs, commit, arready;
    logic [REG_CNT-1:0] aw_hit, ar_hit;
    logic [IW-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] ar_data;
    logic [1:0]            ar_resp;

    logic unused_ok;
    assign unused_ok = ^{axi4_lite_i.awprot, axi4_lite_i.arprot,
                         axi4_lite_i.awaddr, axi4_lite_i.araddr};

    assign aw_hs   = axi4_lite_i.awvalid && !aw_full_q;
    assign w_hs    = axi4_lite_i.wvalid  && !w_full_q;
    assign arready = !r_vld_q || axi4_lite_i.rready;
    assign ar_hs   = axi4_lite_i.arvalid && arready;
    // The B slot is free either when empty or when its response leaves this cycle.
    assign commit  = aw_full_q && w_full_q && (!b_vld_q || axi4_lite_i.bready);
    assign ar_idx  = axi4_lite_i.araddr[ADDR_WIDTH-1:OFFS];

    always_comb begin
        aw_hit = '0;
        ar_hit = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            aw_hit[i] = (aw_idx_q == IW'(i));
            ar_hit[i] = (ar_idx   == IW'(i));
        end
    end

    // Write slots and commit
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_vld_d   = b_vld_q;
        b_resp_d  = b_resp_q;
        regs_d    = regs_q;
        pulse_d   = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = axi4_lite_i.awaddr[ADDR_WIDTH-1:OFFS];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = axi4_lite_i.wdata;
            w_strb_d = axi4_lite_i.wstrb;
        end
        if (b_vld_q && axi4_lite_i.bready) begin
            b_vld_d = 1'b0;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_vld_d   = 1'b1;
            if (aw_hit == '0) begin
                b_resp_d = RESP_DECERR;
            end else if ((aw_hit & RO_MASK) != '0) begin
                b_resp_d = RESP_SLVERR;
            end else begin
                b_resp_d = RESP_OKAY;
            end
            for (int i = 0; i < REG_CNT; i++) begin
                if (aw_hit[i] && !RO_MASK[i]) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < NB; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read lookup uses the registered contents, so a same-cycle write is not visible yet.
    always_comb begin
        ar_data = '0;
        ar_resp = RESP_DECERR;
        for (int i = 0; i < REG_CNT; i++) begin
            if (ar_hit[i]) begin
                ar_data = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
                ar_resp = RESP_OKAY;
            end
        end
    end

    always_comb begin
        r_vld_d  = r_vld_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        if (ar_hs) begin
            r_vld_d  = 1'b1;
            r_data_d = ar_data;
            r_resp_d = ar_resp;
        end else if (r_vld_q && axi4_lite_i.rready) begin
            r_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q    <= '0;
            pulse_q   <= '0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_vld_q   <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_vld_q   <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_vld_q   <= b_vld_d;
            b_resp_q  <= b_resp_d;
            r_vld_q   <= r_vld_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

    assign axi4_lite_i.awready = !aw_full_q;
    assign axi4_lite_i.wready  = !w_full_q;
    assign axi4_lite_i.bvalid  = b_vld_q;
    assign axi4_lite_i.bresp   = b_resp_q;
    assign axi4_lite_i.arready = arready;
    assign axi4_lite_i.rvalid  = r_vld_q;
    assign axi4_lite_i.rdata   = r_data_q;
    assign axi4_lite_i.rresp   = r_resp_q;

    assign wr_pulse_o = pulse_q;

    for (genvar i = 0; i < REG_CNT; i++) begin : g_regs_o
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: timing, strobes, RO/out-of-range responses, B backpressure, async reset.
module tb_axi4_lite_regfile;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RC = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [RC*DW-1:0] status_i;
    logic [RC*DW-1:0] regs_o;
    logic [RC-1:0]    wr_pulse_o;

    int n_tests = 0;
    int n_fail  = 0;

    axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_regfile #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .REG_CNT   (RC),
        .RO_MASK   (8'h80)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .axi4_lite_i(bus),
        .status_i   (status_i),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return regs_o[i*DW +: DW];
    endfunction

    task automatic drive_aw(input logic v, input logic [31:0] a);
        bus.awvalid = v;
        bus.awaddr  = a;
    endtask

    task automatic drive_w(input logic v, input logic [31:0] d, input logic [3:0] s);
        bus.wvalid = v;
        bus.wdata  = d;
        bus.wstrb  = s;
    endtask

    initial begin
        status_i = '0;
        status_i[7*DW +: DW] = 32'hCAFEF00D;
        status_i[0*DW +: DW] = 32'h0BADBEEF;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = 3'b000;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 1'b1;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = 3'b000;
        bus.rready  = 1'b1;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_wready",  32'(bus.wready),  32'd1);
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_pulse",   32'(wr_pulse_o),  32'd0);
        chk("rst_word1",   word(1),          32'd0);

        // Simultaneous AW+W to 0x4
        drive_aw(1'b1, 32'h4);
        drive_w(1'b1, 32'hDEADBEEF, 4'hF);
        @(negedge clk_i);
        drive_aw(1'b0, 32'h0);
        drive_w(1'b0, 32'h0, 4'h0);
        chk("t1_bvalid_c1", 32'(bus.bvalid), 32'd0);
        chk("t1_pulse_c1",  32'(wr_pulse_o), 32'd0);
        @(negedge clk_i);
        chk("t1_bvalid_c2", 32'(bus.bvalid), 32'd1);
        chk("t1_bresp",     32'(bus.bresp),  32'd0);
        chk("t1_pulse_c2",  32'(wr_pulse_o), 32'h02);
        chk("t1_word1",     word(1),         32'hDEADBEEF);
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        @(negedge clk_i);
        bus.arvalid = 1'b0;
        chk("t1_pulse_c3",  32'(wr_pulse_o), 32'd0);
        chk("t1_bvalid_c3", 32'(bus.bvalid), 32'd0);
        chk("t1_rvalid",    32'(bus.rvalid), 32'd1);
        chk("t1_rdata",     bus.rdata,       32'hDEADBEEF);
        chk("t1_rresp",     32'(bus.rresp),  32'd0);

        // W three cycles ahead of AW, partial strobe
        drive_w(1'b1, 32'h12345678, 4'b0101);
        @(negedge clk_i);
        drive_w(1'b0, 32'h0, 4'h0);
        chk("t2_wready_low", 32'(bus.wready),  32'd0);
        chk("t2_awready",    32'(bus.awready), 32'd1);
        chk("t2_rvalid_clr", 32'(bus.rvalid),  32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t2_no_b_early", 32'(bus.bvalid), 32'd0);
        drive_aw(1'b1, 32'h8);
        @(negedge clk_i);
        drive_aw(1'b0, 32'h0);
        chk("t2_bvalid_c1", 32'(bus.bvalid), 32'd0);
        @(negedge clk_i);
        chk("t2_bvalid_c2", 32'(bus.bvalid), 32'd1);
        chk("t2_bresp",     32'(bus.bresp),  32'd0);
        chk("t2_word2",     word(2),         32'h00340078);
        chk("t2_pulse",     32'(wr_pulse_o), 32'h04);
        chk("t2_wready",    32'(bus.wready), 32'd1);
        @(negedge clk_i);
        chk("t2_single_b",  32'(bus.bvalid), 32'd0);

        // Read-only register 7
        drive_aw(1'b1, 32'h1C);
        drive_w(1'b1, 32'h11111111, 4'hF);
        @(negedge clk_i);
        drive_aw(1'b0, 32'h0);
        drive_w(1'b0, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t3_bvalid", 32'(bus.bvalid), 32'd1);
        chk("t3_bresp",  32'(bus.bresp),  32'h2);
        chk("t3_pulse",  32'(wr_pulse_o), 32'd0);
        chk("t3_word7",  word(7),         32'd0);
        bus.arvalid = 1'b1; bus.araddr = 32'h1C;
        @(negedge clk_i);
        bus.arvalid = 1'b0;
        chk("t3_rdata", bus.rdata,      32'hCAFEF00D);
        chk("t3_rresp", 32'(bus.rresp), 32'd0);

        // Out of range index 16
        drive_aw(1'b1, 32'h40);
        drive_w(1'b1, 32'hFFFFFFFF, 4'hF);
        @(negedge clk_i);
        drive_aw(1'b0, 32'h0);
        drive_w(1'b0, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t4_bvalid", 32'(bus.bvalid), 32'd1);
        chk("t4_bresp",  32'(bus.bresp),  32'h3);
        chk("t4_pulse",  32'(wr_pulse_o), 32'd0);
        chk("t4_word0",  word(0),         32'd0);
        chk("t4_word1",  word(1),         32'hDEADBEEF);
        chk("t4_word2",  word(2),         32'h00340078);
        bus.arvalid = 1'b1; bus.araddr = 32'h40;
        @(negedge clk_i);
        bus.arvalid = 1'b0;
        chk("t4_rvalid", 32'(bus.rvalid), 32'd1);
        chk("t4_rdata",  bus.rdata,       32'd0);
        chk("t4_rresp",  32'(bus.rresp),  32'h3);

        // B backpressure: second write parks in the slots until bready
        bus.bready = 1'b0;
        drive_aw(1'b1, 32'hC);
        drive_w(1'b1, 32'hA5A5A5A5, 4'hF);
        @(negedge clk_i);
        drive_aw(1'b0, 32'h0);
        drive_w(1'b0, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t5_b1_valid", 32'(bus.bvalid), 32'd1);
        chk("t5_b1_pulse", 32'(wr_pulse_o), 32'h08);
        chk("t5_word3",    word(3),         32'hA5A5A5A5);
        drive_aw(1'b1, 32'h10);
        drive_w(1'b1, 32'h5A5A5A5A, 4'hF);
        @(negedge clk_i);
        drive_aw(1'b0, 32'h0);
        drive_w(1'b0, 32'h0, 4'h0);
        chk("t5_awready_low", 32'(bus.awready), 32'd0);
        chk("t5_wready_low",  32'(bus.wready),  32'd0);
        chk("t5_b1_hold",     32'(bus.bvalid),  32'd1);
        chk("t5_no_pulse",    32'(wr_pulse_o),  32'd0);
        chk("t5_word4_stall", word(4),          32'd0);
        @(negedge clk_i);
        chk("t5_word4_stall2", word(4),         32'd0);
        chk("t5_b1_hold2",     32'(bus.bvalid), 32'd1);
        bus.bready = 1'b1;
        @(negedge clk_i);
        chk("t5_b2_valid", 32'(bus.bvalid),  32'd1);
        chk("t5_b2_resp",  32'(bus.bresp),   32'd0);
        chk("t5_word4",    word(4),          32'h5A5A5A5A);
        chk("t5_b2_pulse", 32'(wr_pulse_o),  32'h10);
        chk("t5_awready",  32'(bus.awready), 32'd1);
        @(negedge clk_i);
        chk("t5_b_done",   32'(bus.bvalid),  32'd0);

        // Async reset with AW captured, W pending, R held
        bus.rready = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 32'h4;
        drive_aw(1'b1, 32'h14);
        @(negedge clk_i);
        bus.arvalid = 1'b0;
        drive_aw(1'b0, 32'h0);
        chk("t6_rvalid_pre",  32'(bus.rvalid),  32'd1);
        chk("t6_rdata_pre",   bus.rdata,        32'hDEADBEEF);
        chk("t6_awready_pre", 32'(bus.awready), 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rvalid_rst",  32'(bus.rvalid),  32'd0);
        chk("t6_rdata_rst",   bus.rdata,        32'd0);
        chk("t6_awready_rst", 32'(bus.awready), 32'd1);
        chk("t6_arready_rst", 32'(bus.arready), 32'd1);
        chk("t6_word1_rst",   word(1),          32'd0);
        chk("t6_word3_rst",   word(3),          32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        bus.rready = 1'b1;
        @(negedge clk_i);
        drive_w(1'b1, 32'h77777777, 4'hF);
        @(negedge clk_i);
        drive_w(1'b0, 32'h0, 4'h0);
        chk("t6_wready_low", 32'(bus.wready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("t6_no_bvalid", 32'(bus.bvalid), 32'd0);
            chk("t6_no_pulse",  32'(wr_pulse_o), 32'd0);
        end
        chk("t6_word5", word(5), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
